aes256_encrypt_iter: RTL and testbench

- Iterative AES-256 encryption engine. It is the forward counterpart of the decryption datapath.
- Performs one full round per clock: SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Takes a 128-bit plaintext block over a valid/ready handshake and returns the ciphertext over a valid/ready handshake.
- Round keys come from the shared key-schedule store through a combinational-read index port.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_enc_round.sv | 57 +++++
 rtl/aes256_encrypt_iter.sv | 108 ++++++++++
 tb/tb_aes256_encrypt_iter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative cipher datapaths.
// Contents: round count for AES-256, FSM state encoding, forward S-box,
// byte-position helper and GF(2^8) arithmetic (xtime, general multiply).
// No ports.
package aes_pkg;

  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // MSB position of the state byte at (row, col); state is column-major,
  // byte k = 4*col + row sits at [127-8k -: 8].
  function automatic int byte_msb(input int row, input int col);
    return 127 - 8 * (4 * col + row);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round.
// Ports:
//   i_state  128  round input state (column-major bytes)
//   i_rk     128  round key
//   i_last   1    final round: skip MixColumns
//   o_state  128  SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;

  always_comb begin
    w_sb = '0;
    w_sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sb[byte_msb(r, c) -: 8] = sub_byte(i_state[byte_msb(r, c) -: 8]);
      end
    end
    // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[byte_msb(r, c) -: 8] = w_sb[byte_msb(r, (c + r) % 4) -: 8];
      end
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0   = '0;
    a1   = '0;
    a2   = '0;
    a3   = '0;
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = w_sr[byte_msb(0, c) -: 8];
      a1 = w_sr[byte_msb(1, c) -: 8];
      a2 = w_sr[byte_msb(2, c) -: 8];
      a3 = w_sr[byte_msb(3, c) -: 8];
      w_mc[byte_msb(0, c) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      w_mc[byte_msb(1, c) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      w_mc[byte_msb(2, c) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      w_mc[byte_msb(3, c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  assign o_state = (i_last ? w_sr : w_mc) ^ i_rk;

endmodule

// File: rtl/aes256_encrypt_iter.sv
// Iterative AES-256 encryption engine, one round per clock.
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   in_valid/in_ready      plaintext handshake, in_data[127:0] (byte 0 = MSB)
//   out_valid/out_ready    ciphertext handshake, out_data[127:0]
//   rk_idx/rk_data         combinational round-key lookup into the key store
//   busy                   high while a block is in ROUND or DONE
//
// state | meaning
// IDLE  | waiting for a block; rk_idx=0 fetches the whitening key
// ROUND | applying round rnd (1..NR) with key rk_idx=rnd
// DONE  | ciphertext held on out_data until out_ready
module aes256_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR       = NR_256,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_data,
  output logic                busy
);

  localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NR);

  enc_state_e          r_state;
  logic [RK_IDX_W-1:0] r_rnd;
  logic [127:0]        r_data;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic                w_last;
  logic [127:0]        w_round;

  assign w_last = (r_rnd == LAST_RND);

  aes_enc_round u_round (
    .i_state (r_data),
    .i_rk    (rk_data),
    .i_last  (w_last),
    .o_state (w_round)
  );

  // r_rnd is cleared on leaving ROUND so it doubles as the key index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rnd       <= '0;
      r_data      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_data     <= in_data ^ rk_data;
            r_rnd      <= RK_IDX_W'(1);
            r_state    <= ST_ROUND;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_ROUND: begin
          r_data <= w_round;
          if (w_last) begin
            r_rnd       <= '0;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_rnd <= r_rnd + RK_IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rnd       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign rk_idx    = r_rnd;
  assign busy      = r_busy;

endmodule

// File: tb/tb_aes256_encrypt_iter.sv
// Directed bench for aes256_encrypt_iter. Serves expanded round keys on
// rk_idx and checks against FIPS-197 C.3 and a reference cipher model.
module tb_aes256_encrypt_iter;

  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         busy;

  logic [127:0] rk_tab [16];
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rk_data = rk_tab[rk_idx];

  aes256_encrypt_iter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rk_idx(rk_idx), .rk_data(rk_data), .busy(busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic int bo(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

  // S-box from its definition: GF inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, x8;
    for (int x = 0; x < 256; x++) begin
      x8  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[sb[x]] = x8;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i - 1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i - 8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    rk_tab[15] = '0;
  endtask

  function automatic logic [127:0] enc_model(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    s = pt ^ rk_tab[0];
    for (int rd = 1; rd <= 14; rd++) begin
      for (int k = 0; k < 16; k++) t[127 - 8 * k -: 8] = sb[s[127 - 8 * k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[bo(r, c) -: 8] = t[bo(r, (c + r) % 4) -: 8];
      if (rd != 14) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[bo(r, c) -: 8];
          for (int r = 0; r < 4; r++)
            s[bo(r, c) -: 8] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r + 1) % 4]) ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
      end
      s = s ^ rk_tab[rd];
    end
    return s;
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] ct);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    s = ct ^ rk_tab[14];
    for (int rd = 13; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[bo(r, (c + r) % 4) -: 8] = s[bo(r, c) -: 8];
      for (int k = 0; k < 16; k++) s[127 - 8 * k -: 8] = isb[t[127 - 8 * k -: 8]];
      s = s ^ rk_tab[rd];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[bo(r, c) -: 8];
          for (int r = 0; r < 4; r++)
            s[bo(r, c) -: 8] = gmul(8'h0e, a[r]) ^ gmul(8'h0b, a[(r + 1) % 4]) ^
                               gmul(8'h0d, a[(r + 2) % 4]) ^ gmul(8'h09, a[(r + 3) % 4]);
        end
      end
    end
    return s;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pushes one block from IDLE with out_ready=1; returns in IDLE.
  task automatic drive_block(input logic [127:0] pt, output logic [127:0] ct, output int lat);
    in_valid = 1'b1;
    in_data  = pt;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    ct = out_data;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = C3_PT;
    step();
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (rk_idx !== 4'd0) begin n_err++; $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); end
    n_vec++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_no_accept: busy %b want 0", busy); end
  endtask

  task automatic test_c3();
    int lat;
    in_valid = 1'b1;
    in_data  = C3_PT;
    n_vec++; if (in_ready !== 1'b1 || rk_idx !== 4'd0) begin
      n_err++; $display("FAIL c3_idle: in_ready %b rk_idx %0d want 1/0", in_ready, rk_idx);
    end
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      n_vec++; if (rk_idx !== 4'(lat + 1)) begin
        n_err++; $display("FAIL c3_rk_idx: cycle %0d got %0d want %0d", lat, rk_idx, lat + 1);
      end
      step();
      lat++;
    end
    n_vec++; if (lat != 14) begin n_err++; $display("FAIL c3_latency: got %0d edges want 14", lat); end
    n_vec++; if (out_data !== C3_CT) begin n_err++; $display("FAIL c3_ct: got %h want %h", out_data, C3_CT); end
    n_vec++; if (busy !== 1'b1 || in_ready !== 1'b0 || rk_idx !== 4'd0) begin
      n_err++; $display("FAIL c3_done_flags: busy %b in_ready %b rk_idx %0d want 1/0/0", busy, in_ready, rk_idx);
    end
    step();
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL c3_return_idle: in_ready %b out_valid %b busy %b want 1/0/0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = C3_PT;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    n_vec++; if (lat != 14) begin n_err++; $display("FAIL bp_latency: got %0d want 14", lat); end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== C3_CT) begin
        n_err++; $display("FAIL bp_hold: cycle %0d ov %b ir %b data %h want 1/0/%h", i, out_valid, in_ready, out_data, C3_CT);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: in_ready %b out_valid %b want 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (busy !== 1'b0 || out_data !== C3_CT) begin
        n_err++; $display("FAIL bp_no_side_effect: busy %b data %h want 0/%h", busy, out_data, C3_CT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [3];
    logic [127:0] exp [3];
    logic [127:0] got [3];
    int acc_cyc [3];
    int n_in, n_out;
    logic acc;
    pts[0] = C3_PT;
    pts[1] = 128'h0;
    pts[2] = 128'h3243f6a8885a308d313198a2e0370734;
    exp[0] = C3_CT;
    exp[1] = enc_model(pts[1]);
    exp[2] = enc_model(pts[2]);
    n_in = 0;
    n_out = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pts[0];
    for (int cyc = 0; cyc < 120 && n_out < 3; cyc++) begin
      acc = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        got[n_out] = out_data;
        n_out++;
      end
      step();
      if (acc) begin
        acc_cyc[n_in] = cyc;
        n_in++;
        if (n_in < 3) in_data = pts[n_in];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_vec++; if (n_out != 3) begin n_err++; $display("FAIL b2b_count: got %0d outputs want 3", n_out); end
    for (int i = 0; i < n_out; i++) begin
      n_vec++; if (got[i] !== exp[i]) begin n_err++; $display("FAIL b2b_ct%0d: got %h want %h", i, got[i], exp[i]); end
    end
    for (int i = 1; i < n_in; i++) begin
      n_vec++; if (acc_cyc[i] - acc_cyc[i - 1] != 16) begin
        n_err++; $display("FAIL b2b_spacing%0d: got %0d want 16", i, acc_cyc[i] - acc_cyc[i - 1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int w, lat;
    logic [127:0] ct;
    in_valid = 1'b1;
    in_data  = C3_PT;
    step();
    in_valid = 1'b0;
    w = 0;
    while (rk_idx !== 4'd7 && w < 40) begin
      step();
      w++;
    end
    n_vec++; if (w != 6) begin n_err++; $display("FAIL mr_reach_rnd7: got %0d cycles want 6", w); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0) begin
      n_err++; $display("FAIL mr_flags: ir %b ov %b busy %b rk %0d want 1/0/0/0", in_ready, out_valid, busy, rk_idx);
    end
    n_vec++; if (out_data !== 128'h0) begin n_err++; $display("FAIL mr_state_clear: got %h want 0", out_data); end
    drive_block(C3_PT, ct, lat);
    n_vec++; if (lat != 14 || ct !== C3_CT) begin
      n_err++; $display("FAIL mr_after: lat %0d ct %h want 14/%h", lat, ct, C3_CT);
    end
  endtask

  task automatic test_busy_reject();
    int lat, pulses;
    in_valid = 1'b1;
    in_data  = C3_PT;
    step();
    lat = 0;
    while (lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
      lat++;
      if (out_valid === 1'b1) break;
    end
    in_valid = 1'b0;
    n_vec++; if (lat != 14) begin n_err++; $display("FAIL br_latency: got %0d want 14", lat); end
    n_vec++; if (out_data !== C3_CT) begin n_err++; $display("FAIL br_ct: got %h want %h", out_data, C3_CT); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid === 1'b1 || busy !== 1'b0) pulses++;
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL br_extra_activity: got %0d busy/valid cycles want 0", pulses); end
  endtask

  task automatic test_round_trip();
    logic [127:0] pt, ct;
    int lat;
    for (int i = 0; i < 100; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      drive_block(pt, ct, lat);
      n_vec++; if (lat != 14 || ct !== enc_model(pt)) begin
        n_err++; $display("FAIL rt_enc%0d: lat %0d ct %h want 14/%h", i, lat, ct, enc_model(pt));
      end
      n_vec++; if (dec_model(ct) !== pt) begin
        n_err++; $display("FAIL rt_dec%0d: got %h want %h", i, dec_model(ct), pt);
      end
    end
  endtask

  initial begin
    build_sbox();
    expand_key(C3_KEY);
    test_reset();
    test_c3();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_busy_reject();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
